// File: rtl/ccl_blob_extractor.sv
// ccl_blob_extractor: single-pass connected-component labeller emitting per-blob area/bbox descriptors.
// Define CCL_CENTROID_EN to add per-blob sum_x/sum_y accumulators and outputs.
module ccl_blob_extractor #(
  parameter int HRES = 1280,
  parameter int VRES = 720,
  parameter int MAX_LABELS = 256,
  parameter int MIN_AREA = 10,
  parameter int CONN8 = 0,
  localparam int LW = $clog2(MAX_LABELS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          mask_in,
  input  logic          valid_in,
  output logic          blob_valid_out,
  input  logic          blob_ready_in,
  output logic [LW-1:0] blob_label_out,
  output logic [31:0]   blob_area_out,
  output logic [10:0]   blob_xmin_out,
  output logic [10:0]   blob_xmax_out,
  output logic [9:0]    blob_ymin_out,
  output logic [9:0]    blob_ymax_out,
  output logic          busy_out,
  output logic          overflow_out,
  output logic          frame_drop_out
`ifdef CCL_CENTROID_EN
  ,
  output logic [31:0]   blob_sumx_out,
  output logic [31:0]   blob_sumy_out
`endif
);
  localparam int HW = $clog2(HRES);
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, RESOLVE = 3'd2, EMIT = 3'd3, CLEAR = 3'd4;
  localparam logic [LW:0] NL_MAX = (LW+1)'(MAX_LABELS);
  localparam logic [LW:0] ONE = (LW+1)'(1);
  logic [2:0] state;
  logic [LW:0] next_label, nl_next, idx;
  logic [LW-1:0] line_buf [HRES];
  logic [LW-1:0] parent [MAX_LABELS];
  logic [31:0] area [MAX_LABELS];
  logic [10:0] xmn [MAX_LABELS];
  logic [10:0] xmx [MAX_LABELS];
  logic [9:0] ymn [MAX_LABELS];
  logic [9:0] ymx [MAX_LABELS];
  logic [MAX_LABELS-1:0] dead;
  logic [LW-1:0] left_q, ul_q, m, lbl, ri, p;
  logic [LW-1:0] nb [4];
  logic [LW-1:0] rt [4];
  logic [HW-1:0] hx;
  logic start, last, proc, any, alloc, ovf;
`ifdef CCL_CENTROID_EN
  logic [31:0] sx [MAX_LABELS];
  logic [31:0] sy [MAX_LABELS];
`endif

  assign busy_out = state != IDLE;
  assign hx = hcount_in[HW-1:0];
  assign ri = idx[LW-1:0];
  assign p = parent[ri];
  assign start = hcount_in == '0 && vcount_in == '0;
  assign last = hcount_in == 11'(HRES-1) && vcount_in == 10'(VRES-1);
  assign proc = valid_in && (state == SCAN ? !start : state == IDLE && start);

  // neighbours: left, above, above-left (latched from the previous read), above-right
  always_comb begin
    nb[0] = hcount_in == '0 ? '0 : left_q;
    nb[1] = vcount_in == '0 ? '0 : line_buf[hx];
    nb[2] = (CONN8 == 0 || hcount_in == '0 || vcount_in == '0) ? '0 : ul_q;
    nb[3] = (CONN8 == 0 || vcount_in == '0 || hcount_in == 11'(HRES-1)) ? '0 : line_buf[hx + HW'(1)];
    m = '1;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rt[i] = nb[i] == '0 ? '0 : parent[nb[i]];
      any = any | (rt[i] != '0);
      m = (rt[i] != '0 && rt[i] < m) ? rt[i] : m;
    end
    alloc = proc && mask_in && !any && next_label != NL_MAX;
    ovf = proc && mask_in && !any && next_label == NL_MAX;
    nl_next = next_label + (LW+1)'(alloc);
    lbl = !mask_in ? '0 : any ? m : alloc ? next_label[LW-1:0] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= CLEAR;
      idx <= '0;
      next_label <= ONE;
      left_q <= '0;
      ul_q <= '0;
      overflow_out <= 1'b0;
      frame_drop_out <= 1'b0;
      blob_valid_out <= 1'b0;
      blob_label_out <= '0;
      blob_area_out <= '0;
      blob_xmin_out <= '0;
      blob_xmax_out <= '0;
      blob_ymin_out <= '0;
      blob_ymax_out <= '0;
`ifdef CCL_CENTROID_EN
      blob_sumx_out <= '0;
      blob_sumy_out <= '0;
`endif
    end else begin
      frame_drop_out <= valid_in && start && state != IDLE;
      case (state)
        IDLE: if (valid_in && start) begin
          state <= SCAN;
          overflow_out <= 1'b0;
        end
        SCAN: if (valid_in && start) begin
          state <= CLEAR;
          idx <= '0;
        end else if (valid_in && last) begin
          state <= RESOLVE;
          idx <= nl_next - ONE;
        end
        // descending walk folds every chain into its final root
        RESOLVE: if (idx == '0) begin
          state <= EMIT;
          idx <= ONE;
        end else begin
          if (p != ri) begin
            area[p] <= area[p] + area[ri];
            xmn[p] <= xmn[ri] < xmn[p] ? xmn[ri] : xmn[p];
            xmx[p] <= xmx[ri] > xmx[p] ? xmx[ri] : xmx[p];
            ymn[p] <= ymn[ri] < ymn[p] ? ymn[ri] : ymn[p];
            ymx[p] <= ymx[ri] > ymx[p] ? ymx[ri] : ymx[p];
`ifdef CCL_CENTROID_EN
            sx[p] <= sx[p] + sx[ri];
            sy[p] <= sy[p] + sy[ri];
`endif
            dead[ri] <= 1'b1;
          end
          idx <= idx - ONE;
        end
        EMIT: if (!blob_valid_out || blob_ready_in) begin
          if (idx >= next_label) begin
            blob_valid_out <= 1'b0;
            state <= CLEAR;
            idx <= '0;
          end else begin
            blob_valid_out <= !dead[ri] && area[ri] >= 32'(MIN_AREA);
            blob_label_out <= ri;
            blob_area_out <= area[ri];
            blob_xmin_out <= xmn[ri];
            blob_xmax_out <= xmx[ri];
            blob_ymin_out <= ymn[ri];
            blob_ymax_out <= ymx[ri];
`ifdef CCL_CENTROID_EN
            blob_sumx_out <= sx[ri];
            blob_sumy_out <= sy[ri];
`endif
            idx <= idx + ONE;
          end
        end
        default: begin
          parent[ri] <= ri;
          area[ri] <= '0;
          xmn[ri] <= '1;
          xmx[ri] <= '0;
          ymn[ri] <= '1;
          ymx[ri] <= '0;
`ifdef CCL_CENTROID_EN
          sx[ri] <= '0;
          sy[ri] <= '0;
`endif
          dead[ri] <= 1'b0;
          idx <= idx + ONE;
          if (idx == NL_MAX - ONE) begin
            state <= IDLE;
            next_label <= ONE;
          end
        end
      endcase
      if (proc) begin
        line_buf[hx] <= lbl;
        left_q <= lbl;
        ul_q <= line_buf[hx];
        if (mask_in)
          for (int i = 0; i < 4; i++)
            if (rt[i] != '0 && rt[i] != m) parent[rt[i]] <= m;
        if (alloc) begin
          next_label <= nl_next;
          area[lbl] <= 32'd1;
          xmn[lbl] <= hcount_in;
          xmx[lbl] <= hcount_in;
          ymn[lbl] <= vcount_in;
          ymx[lbl] <= vcount_in;
`ifdef CCL_CENTROID_EN
          sx[lbl] <= 32'(hcount_in);
          sy[lbl] <= 32'(vcount_in);
`endif
        end else if (mask_in && any) begin
          area[m] <= area[m] + 32'd1;
          xmn[m] <= hcount_in < xmn[m] ? hcount_in : xmn[m];
          xmx[m] <= hcount_in > xmx[m] ? hcount_in : xmx[m];
          ymn[m] <= vcount_in < ymn[m] ? vcount_in : ymn[m];
          ymx[m] <= vcount_in > ymx[m] ? vcount_in : ymx[m];
`ifdef CCL_CENTROID_EN
          sx[m] <= sx[m] + 32'(hcount_in);
          sy[m] <= sy[m] + 32'(vcount_in);
`endif
        end
        if (ovf) overflow_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ccl_blob_extractor.sv
// tb_ccl_blob_extractor: directed frames against three blob extractor configurations.
module tb_ccl_blob_extractor;
  typedef struct {
    int f;
    int d;
    int lab;
    int area;
    int xa;
    int xb;
    int ya;
    int yb;
  } desc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] h = '0;
  logic [9:0] v = '0;
  logic msk = 1'b0;
  logic vld = 1'b0;
  logic [2:0] rdy = 3'b111;
  logic [2:0] bv, bsy, ov, fd;
  logic [1:0] lab [3];
  logic [31:0] ar [3];
  logic [10:0] x0 [3];
  logic [10:0] x1 [3];
  logic [9:0] y0 [3];
  logic [9:0] y1 [3];
  desc_t tbl [$];
  desc_t got [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // d0: 4-conn MIN_AREA=1, d1: 8-conn MIN_AREA=1, d2: 4-conn MIN_AREA=4
  for (genvar g = 0; g < 3; g++) begin : u
    ccl_blob_extractor #(.HRES(16), .VRES(8), .MAX_LABELS(4), .MIN_AREA(g == 2 ? 4 : 1), .CONN8(g == 1 ? 1 : 0)) dut (
      .clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v), .mask_in(msk), .valid_in(vld),
      .blob_valid_out(bv[g]), .blob_ready_in(rdy[g]), .blob_label_out(lab[g]), .blob_area_out(ar[g]),
      .blob_xmin_out(x0[g]), .blob_xmax_out(x1[g]), .blob_ymin_out(y0[g]), .blob_ymax_out(y1[g]),
      .busy_out(bsy[g]), .overflow_out(ov[g]), .frame_drop_out(fd[g]));
  end

  function automatic desc_t mk(input int f, input int d, input int l, input int a,
                               input int xa, input int xb, input int ya, input int yb);
    desc_t r;
    r.f = f; r.d = d; r.lab = l; r.area = a; r.xa = xa; r.xb = xb; r.ya = ya; r.yb = yb;
    return r;
  endfunction

  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (bv[g] && rdy[g])
        got.push_back(mk(0, g, int'(lab[g]), int'(ar[g]), int'(x0[g]), int'(x1[g]), int'(y0[g]), int'(y1[g])));

  function automatic logic pix(input int f, input int x, input int y);
    case (f)
      0, 5, 6: return x >= 2 && x <= 4 && y >= 1 && y <= 3;
      1: return ((x == 2 || x == 6) && y <= 3) || (y == 4 && x >= 2 && x <= 6);
      2: return (x == 3 && y == 2) || (x == 4 && y == 3);
      3: return (y == 1 && x >= 1 && x <= 3) || (y == 5 && x >= 8 && x <= 12);
      default: return y == 1 && (x == 1 || x == 5 || x == 9 || x == 13);
    endcase
  endfunction

  task automatic chk(input string nm, input int a, input int b);
    total++;
    if (a != b) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, b);
    end
  endtask

  task automatic drive_frame(input int f);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        h = 11'(x);
        v = 10'(y);
        msk = pix(f, x, y);
        vld = 1'b1;
        @(posedge clk); #1;
      end
    vld = 1'b0;
    msk = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bsy != 3'b000 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(bsy), 0);
  endtask

  task automatic check_frame(input int f);
    desc_t q [$];
    int k;
    for (int g = 0; g < 3; g++) begin
      q.delete();
      k = 0;
      foreach (got[i]) if (got[i].d == g) q.push_back(got[i]);
      foreach (tbl[i]) if (tbl[i].f == f && tbl[i].d == g) begin
        total++;
        if (k >= q.size()) begin
          bad++;
          $display("FAIL f%0d d%0d desc%0d missing want lab=%0d area=%0d", f, g, k, tbl[i].lab, tbl[i].area);
        end else if (q[k].lab != tbl[i].lab || q[k].area != tbl[i].area || q[k].xa != tbl[i].xa ||
                     q[k].xb != tbl[i].xb || q[k].ya != tbl[i].ya || q[k].yb != tbl[i].yb) begin
          bad++;
          $display("FAIL f%0d d%0d desc%0d got lab=%0d area=%0d x=%0d..%0d y=%0d..%0d want lab=%0d area=%0d x=%0d..%0d y=%0d..%0d",
                   f, g, k, q[k].lab, q[k].area, q[k].xa, q[k].xb, q[k].ya, q[k].yb,
                   tbl[i].lab, tbl[i].area, tbl[i].xa, tbl[i].xb, tbl[i].ya, tbl[i].yb);
        end
        k++;
      end
      total++;
      if (q.size() != k) begin
        bad++;
        $display("FAIL f%0d d%0d count got=%0d want=%0d", f, g, q.size(), k);
      end
    end
    got.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [75:0] snap;
    for (int g = 0; g < 3; g++) begin
      tbl.push_back(mk(0, g, 1, 9, 2, 4, 1, 3));
      tbl.push_back(mk(1, g, 1, 13, 2, 6, 0, 4));
      tbl.push_back(mk(6, g, 1, 9, 2, 4, 1, 3));
    end
    tbl.push_back(mk(2, 0, 1, 1, 3, 3, 2, 2));
    tbl.push_back(mk(2, 0, 2, 1, 4, 4, 3, 3));
    tbl.push_back(mk(2, 1, 1, 2, 3, 4, 2, 3));
    for (int g = 0; g < 2; g++) begin
      tbl.push_back(mk(3, g, 1, 3, 1, 3, 1, 1));
      tbl.push_back(mk(3, g, 2, 5, 8, 12, 5, 5));
      tbl.push_back(mk(4, g, 1, 1, 1, 1, 1, 1));
      tbl.push_back(mk(4, g, 2, 1, 5, 5, 1, 1));
      tbl.push_back(mk(4, g, 3, 1, 9, 9, 1, 1));
    end
    tbl.push_back(mk(3, 2, 2, 5, 8, 12, 5, 5));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bv), 0);
    chk("rst_busy", int'(bsy), 7);
    chk("rst_overflow", int'(ov), 0);
    chk("rst_drop", int'(fd), 0);
    chk("rst_area", int'(ar[0]), 0);
    rst = 1'b0;
    wait_idle();

    for (int f = 0; f < 3; f++) begin
      drive_frame(f);
      wait_idle();
      check_frame(f);
    end

    rdy[2] = 1'b0;
    drive_frame(3);
    n = 0;
    while (!bv[2] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid", int'(bv[2]), 1);
    snap = {lab[2], ar[2], x0[2], x1[2], y0[2], y1[2]};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (!bv[2] || {lab[2], ar[2], x0[2], x1[2], y0[2], y1[2]} != snap) begin
        bad++;
        $display("FAIL stall_hold cycle%0d got valid=%0d desc=%0h want valid=1 desc=%0h", i, bv[2],
                 {lab[2], ar[2], x0[2], x1[2], y0[2], y1[2]}, snap);
      end
    end
    rdy[2] = 1'b1;
    wait_idle();
    check_frame(3);

    drive_frame(4);
    chk("overflow_set", int'(ov), 7);
    wait_idle();
    check_frame(4);
    chk("overflow_sticky", int'(ov), 7);

    rdy[0] = 1'b0;
    drive_frame(5);
    chk("overflow_clear", int'(ov), 0);
    n = 0;
    while (!bv[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("emit_before_rst", int'(bv[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_emit_valid", int'(bv[0]), 0);
    chk("rst_emit_busy0", int'(bsy), 7);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_clear_busy", int'(bsy), 7);
    end
    @(posedge clk); #1;
    chk("rst_clear_done", int'(bsy), 0);
    rdy[0] = 1'b1;
    got.delete();

    drive_frame(6);
    h = '0;
    v = '0;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    chk("drop_pulse", int'(fd), 7);
    @(posedge clk); #1;
    chk("drop_end", int'(fd), 0);
    wait_idle();
    check_frame(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
